cdc_fifo_gray_src_mc: RTL and testbench
=======================================

// Module: cdc_fifo_gray_src_mc
// PURPOSE
//  Source (write) half of NumChan independent gray-pointer async FIFOs, all in one clock domain.
//  Generalises the per-channel src halves used in AXI CDC: adds fill level and almost-full flags per channel.
//  Pairs with a matching dst half in the other domain via async data/wptr/rptr buses.
//  One clock; reset is asynchronous and active-high.
// PARAMETERS
//  NumChan          5                 number of independent channels
//  DataWidth        64                payload bits per channel entry
//  LogDepth         2                 log2 of entries per channel (>=1)
//  SyncStages       2                 rptr synchroniser flops (>=2)
//  AlmostFullThresh 2**LogDepth-1     fill level at/above which almost_full asserts (1..2**LogDepth)
// PORTS
//  src_clk_i         in   1                                  source clock
//  src_rst_i         in   1                                  async active-high reset
//  src_data_i        in   NumChan*DataWidth                  per-channel write payload
//  src_valid_i       in   NumChan                            per-channel write valid
//  src_ready_o       out  NumChan                            per-channel not-full
//  src_fill_o        out  NumChan*(LogDepth+1)               entries in flight (src view)
//  src_almost_full_o out  NumChan                            fill >= AlmostFullThresh
//  async_data_o      out  NumChan*2**LogDepth*DataWidth      storage array, to dst domain
//  async_wptr_o      out  NumChan*(LogDepth+1)               gray write pointer, registered
//  async_rptr_i      in   NumChan*(LogDepth+1)               gray read pointer from dst domain
// BEHAVIOUR
//  Reset (async, immediate): wptr bin/gray=0, sync flops=0, storage=0; ready=1, fill=0, almost_full=0.
//  Channels fully independent; no shared arbitration or state.
//  Handshake: transfer when valid&&ready at posedge. ready is a function of registers only, never of valid.
//   valid, once high, holds with stable data until ready (bench asserts; RTL does not rely on it).
//  On transfer: mem[wptr_bin[LogDepth-1:0]] <= data; wptr_bin += 1 (mod 2**(LogDepth+1)).
//   async_wptr_o = gray register updated the same edge: visible 1 cycle after the handshake.
//   Gray register driven from flops only (no comb logic on the CDC path).
//  rptr path: async_rptr_i -> SyncStages flops -> gray2bin = rptr_sync_bin.
//  full: wptr_gray == {~rptr_sync_gray[top:top-1], rptr_sync_gray[top-2:0]}; ready = !full.
//  fill = wptr_bin - rptr_sync_bin, (LogDepth+1)-bit modular; range 0..2**LogDepth.
//   Freed space reflected SyncStages cycles after async_rptr_i changes.
//  almost_full = (fill >= AlmostFullThresh); registered-input comb, no extra latency.
//  Wrap-around: pointer MSB toggles every 2**LogDepth writes; slot index wraps to 0.
//  Simultaneous write + rptr advance: write judged on current (pre-edge) full; both take effect same edge.
//  At full, valid held: no write, no pointer change, data not overwritten.
//  Reset mid-operation: in-flight entries discarded; dst half must be reset in the same reset window (system rule).
//  No X on outputs after reset; storage entries only change on a write to that slot.
// STRUCTURE
//  cdc_gray_pkg: functions bin2gray/gray2bin (parametrised width), ptr width constant helper.
//  Sub-module cdc_gray_src_slice: one channel (storage, wptr, sync, full, fill); top generates NumChan copies.
//  Sync flops carry a synchroniser attribute / false-path tag for STA.
// TESTING (NumChan=2, LogDepth=2, SyncStages=2, AlmostFullThresh=3)
//  Reset: src_rst_i=1 -> ready=2'b11, fill=0, almost_full=0, all async_wptr_o=0, storage 0.
//  Fill ch0: rptr ch0=0, 4 writes -> wptr gray 001,011,010,110; almost_full after 3rd; ready=0, fill=4 after 4th; ch1 untouched.
//  Drain: after fill, async_rptr_i ch0=3'b010 (bin 3) -> 2 cycles later fill=1, ready=1, almost_full=0.
//  Wrap: 9 writes, rptr tracking wptr with 2-cycle lag -> wptr bin 7->0 (gray 100->000), data lands in slot 0.
//  Full+free same edge: full, valid=1, rptr sync frees 1 on edge N -> no write at N, write at N+1; fill 4->3->4.
//  Mid-op reset: fill=3 on ch0, pulse src_rst_i mid-cycle -> outputs reset immediately without clock; resumes clean.

Source files
------------

// File: rtl/cdc_gray_pkg.sv
// Gray-code helpers shared by the source-side async FIFO pointer logic.
// Functions work on a 32-bit container; callers cast to the pointer width.
package cdc_gray_pkg;

    function automatic int unsigned ptr_width(int unsigned log_depth);
        return log_depth + 1;
    endfunction

    function automatic logic [31:0] bin2gray(logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Zero-extended inputs convert correctly because the unused upper bits stay 0.
    function automatic logic [31:0] gray2bin(logic [31:0] gray);
        logic [31:0] bin;
        bin = gray;
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i + 1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/cdc_gray_src_slice.sv
// One channel of the write side of a gray-pointer async FIFO: storage, write
// pointer, read-pointer synchroniser, full/fill/almost-full status.
import cdc_gray_pkg::*;

module cdc_gray_src_slice #(
    parameter int DataWidth        = 64,
    parameter int LogDepth         = 2,
    parameter int SyncStages       = 2,
    parameter int AlmostFullThresh = 2**LogDepth - 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [DataWidth-1:0]               data_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    output logic [LogDepth:0]                  fill_o,
    output logic                               almost_full_o,
    output logic [(2**LogDepth)*DataWidth-1:0] mem_o,
    output logic [LogDepth:0]                  wptr_o,
    input  logic [LogDepth:0]                  rptr_i
);

    localparam int PtrW  = ptr_width(LogDepth);
    localparam int Depth = 2**LogDepth;
    // Full when the two top gray bits differ and the rest match.
    localparam logic [PtrW-1:0] FullMask = PtrW'(2'b11) << (PtrW - 2);

    logic [PtrW-1:0]      wptr_bin_q;
    logic [PtrW-1:0]      wptr_bin_d;
    logic [PtrW-1:0]      wptr_gray_q;
    logic [PtrW-1:0]      wptr_gray_d;
    (* async_reg = "true" *)
    logic [PtrW-1:0]      rptr_sync_q [SyncStages];
    logic [DataWidth-1:0] mem_q [Depth];

    logic [PtrW-1:0] rptr_sync_gray;
    logic [PtrW-1:0] rptr_sync_bin;
    logic [PtrW-1:0] fill;
    logic            full;
    logic            write;

    always_comb begin
        rptr_sync_gray = rptr_sync_q[SyncStages-1];
        rptr_sync_bin  = PtrW'(gray2bin(32'(rptr_sync_gray)));
        full           = ((wptr_gray_q ^ rptr_sync_gray) == FullMask);
        write          = valid_i && !full;
        wptr_bin_d     = write ? wptr_bin_q + PtrW'(1) : wptr_bin_q;
        wptr_gray_d    = PtrW'(bin2gray(32'(wptr_bin_d)));
        fill           = wptr_bin_q - rptr_sync_bin;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_bin_q  <= '0;
            wptr_gray_q <= '0;
            for (int i = 0; i < SyncStages; i++) begin
                rptr_sync_q[i] <= '0;
            end
        end else begin
            wptr_bin_q     <= wptr_bin_d;
            wptr_gray_q    <= wptr_gray_d;
            rptr_sync_q[0] <= rptr_i;
            for (int i = 1; i < SyncStages; i++) begin
                rptr_sync_q[i] <= rptr_sync_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (write) begin
            mem_q[wptr_bin_q[LogDepth-1:0]] <= data_i;
        end
    end

    assign ready_o       = !full;
    assign fill_o        = fill;
    assign almost_full_o = (fill >= PtrW'(AlmostFullThresh));
    assign wptr_o        = wptr_gray_q;

    for (genvar s = 0; s < Depth; s++) begin : g_slot
        assign mem_o[s*DataWidth +: DataWidth] = mem_q[s];
    end

endmodule

// File: rtl/cdc_fifo_gray_src_mc.sv
// Write halves of NumChan independent gray-pointer async FIFOs in one clock
// domain; each channel is a self-contained slice with no shared state.
import cdc_gray_pkg::*;

module cdc_fifo_gray_src_mc #(
    parameter int NumChan          = 5,
    parameter int DataWidth        = 64,
    parameter int LogDepth         = 2,
    parameter int SyncStages       = 2,
    parameter int AlmostFullThresh = 2**LogDepth - 1
) (
    input  logic                                       src_clk_i,
    input  logic                                       src_rst_i,
    input  logic [NumChan*DataWidth-1:0]               src_data_i,
    input  logic [NumChan-1:0]                         src_valid_i,
    output logic [NumChan-1:0]                         src_ready_o,
    output logic [NumChan*(LogDepth+1)-1:0]            src_fill_o,
    output logic [NumChan-1:0]                         src_almost_full_o,
    output logic [NumChan*(2**LogDepth)*DataWidth-1:0] async_data_o,
    output logic [NumChan*(LogDepth+1)-1:0]            async_wptr_o,
    input  logic [NumChan*(LogDepth+1)-1:0]            async_rptr_i
);

    localparam int PtrW  = ptr_width(LogDepth);
    localparam int ChanW = (2**LogDepth) * DataWidth;

    for (genvar c = 0; c < NumChan; c++) begin : g_chan
        cdc_gray_src_slice #(
            .DataWidth       (DataWidth),
            .LogDepth        (LogDepth),
            .SyncStages      (SyncStages),
            .AlmostFullThresh(AlmostFullThresh)
        ) u_slice (
            .clk_i        (src_clk_i),
            .rst_i        (src_rst_i),
            .data_i       (src_data_i[c*DataWidth +: DataWidth]),
            .valid_i      (src_valid_i[c]),
            .ready_o      (src_ready_o[c]),
            .fill_o       (src_fill_o[c*PtrW +: PtrW]),
            .almost_full_o(src_almost_full_o[c]),
            .mem_o        (async_data_o[c*ChanW +: ChanW]),
            .wptr_o       (async_wptr_o[c*PtrW +: PtrW]),
            .rptr_i       (async_rptr_i[c*PtrW +: PtrW])
        );
    end

endmodule

// File: tb/tb_cdc_fifo_gray_src_mc.sv
// Bench for the multi-channel async FIFO write half: queue-level model checked
// every cycle plus directed scenarios with literal expectations.
module tb_cdc_fifo_gray_src_mc;

    localparam int NC = 2;
    localparam int DW = 16;
    localparam int LD = 2;
    localparam int PW = LD + 1;

    logic                  clk;
    logic                  rst;
    logic [NC*DW-1:0]      data;
    logic [NC-1:0]         valid;
    logic [NC-1:0]         ready;
    logic [NC*PW-1:0]      fill;
    logic [NC-1:0]         af;
    logic [NC*4*DW-1:0]    adata;
    logic [NC*PW-1:0]      wptr;
    logic [NC*PW-1:0]      rptr;

    int checks   = 0;
    int failures = 0;
    logic cmp_en = 1'b0;

    cdc_fifo_gray_src_mc #(
        .NumChan(NC), .DataWidth(DW), .LogDepth(LD),
        .SyncStages(2), .AlmostFullThresh(3)
    ) dut (
        .src_clk_i        (clk),
        .src_rst_i        (rst),
        .src_data_i       (data),
        .src_valid_i      (valid),
        .src_ready_o      (ready),
        .src_fill_o       (fill),
        .src_almost_full_o(af),
        .async_data_o     (adata),
        .async_wptr_o     (wptr),
        .async_rptr_i     (rptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] g2b(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    // Model: write count, read count as seen two edges late, and slot contents.
    logic [2:0]  m_wcnt [NC];
    logic [2:0]  m_rs0  [NC];
    logic [2:0]  m_rs1  [NC];
    logic [15:0] m_mem  [NC][4];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NC; c++) begin
                m_wcnt[c] <= 3'd0;
                m_rs0[c]  <= 3'd0;
                m_rs1[c]  <= 3'd0;
                for (int s = 0; s < 4; s++) m_mem[c][s] <= 16'h0;
            end
        end else begin
            for (int c = 0; c < NC; c++) begin
                if (valid[c] && (3'(m_wcnt[c] - m_rs1[c]) != 3'd4)) begin
                    m_mem[c][m_wcnt[c][1:0]] <= data[c*DW +: DW];
                    m_wcnt[c] <= m_wcnt[c] + 3'd1;
                end
                m_rs1[c] <= m_rs0[c];
                m_rs0[c] <= g2b(rptr[c*PW +: PW]);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int c = 0; c < NC; c++) begin
                logic [2:0]  ef;
                logic [63:0] emem;
                ef   = 3'(m_wcnt[c] - m_rs1[c]);
                emem = {m_mem[c][3], m_mem[c][2], m_mem[c][1], m_mem[c][0]};
                chk("cyc_fill",  64'(fill[c*PW +: PW]), 64'(ef));
                chk("cyc_ready", 64'(ready[c]), 64'(ef != 3'd4));
                chk("cyc_af",    64'(af[c]), 64'(ef >= 3'd3));
                chk("cyc_wptr",  64'(wptr[c*PW +: PW]), 64'(m_wcnt[c] ^ (m_wcnt[c] >> 1)));
                chk("cyc_mem",   adata[c*64 +: 64], emem);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic [15:0] slot(input int c, input int s);
        return adata[c*64 + s*DW +: DW];
    endfunction

    logic [2:0] fill_g [4] = '{3'b001, 3'b011, 3'b010, 3'b110};

    initial begin
        rst   = 1'b1;
        valid = '0;
        data  = '0;
        rptr  = '0;
        cmp_en = 1'b1;
        cyc(); cyc();
        chk("rst_ready", 64'(ready), 64'(2'b11));
        chk("rst_fill",  64'(fill), 64'h0);
        chk("rst_af",    64'(af), 64'h0);
        chk("rst_wptr",  64'(wptr), 64'h0);
        chk("rst_data",  adata[63:0] | adata[127:64], 64'h0);
        rst = 1'b0;
        cyc();

        // fill channel 0 to full
        for (int i = 0; i < 4; i++) begin
            valid[0]   = 1'b1;
            data[15:0] = 16'(16'hA0 + i);
            cyc();
            chk("fill_wptr", 64'(wptr[2:0]), 64'(fill_g[i]));
            chk("fill_af",   64'(af[0]), 64'(i >= 2));
        end
        valid[0] = 1'b0;
        chk("fill_ready", 64'(ready[0]), 64'h0);
        chk("fill_lvl",   64'(fill[2:0]), 64'd4);
        chk("fill_slot3", 64'(slot(0, 3)), 64'hA3);
        chk("ch1_wptr",   64'(wptr[5:3]), 64'h0);
        chk("ch1_fill",   64'(fill[5:3]), 64'h0);

        // drain: reader at bin 3, seen two edges later
        rptr[2:0] = 3'b010;
        cyc();
        chk("drain_lag", 64'(fill[2:0]), 64'd4);
        cyc();
        chk("drain_fill",  64'(fill[2:0]), 64'd1);
        chk("drain_ready", 64'(ready[0]), 64'd1);
        chk("drain_af",    64'(af[0]), 64'd0);

        // wrap on channel 1 with reader trailing the writer
        for (int i = 0; i < 9; i++) begin
            logic [2:0] ib;
            ib = 3'(i);
            rptr[5:3]   = ib ^ (ib >> 1);
            valid[1]    = 1'b1;
            data[31:16] = 16'(16'hB0 + i);
            cyc();
            if (i == 6) chk("wrap_g7", 64'(wptr[5:3]), 64'(3'b100));
            if (i == 7) chk("wrap_g0", 64'(wptr[5:3]), 64'(3'b000));
            if (i == 8) begin
                chk("wrap_slot0", 64'(slot(1, 0)), 64'hB8);
                chk("wrap_g1",    64'(wptr[5:3]), 64'(3'b001));
            end
        end
        valid[1] = 1'b0;

        // channel 0: refill, then free one slot while a write is pending
        valid[0] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            data[15:0] = 16'(16'hD0 + j);
            cyc();
        end
        chk("ff_full_lvl",   64'(fill[2:0]), 64'd4);
        chk("ff_full_ready", 64'(ready[0]), 64'd0);
        data[15:0] = 16'hC0;
        rptr[2:0]  = 3'b110;
        cyc();
        chk("ff_hold_lvl",  64'(fill[2:0]), 64'd4);
        chk("ff_hold_wptr", 64'(wptr[2:0]), 64'(3'b100));
        chk("ff_hold_mem",  64'(slot(0, 3)), 64'hA3);
        cyc();
        chk("ff_free_lvl",   64'(fill[2:0]), 64'd3);
        chk("ff_free_ready", 64'(ready[0]), 64'd1);
        chk("ff_free_wptr",  64'(wptr[2:0]), 64'(3'b100));
        cyc();
        chk("ff_wr_lvl",  64'(fill[2:0]), 64'd4);
        chk("ff_wr_wptr", 64'(wptr[2:0]), 64'(3'b000));
        chk("ff_wr_mem",  64'(slot(0, 3)), 64'hC0);
        valid[0] = 1'b0;

        // asynchronous reset in the middle of a cycle
        rptr[2:0] = 3'b111;
        cyc(); cyc();
        chk("mid_pre_fill", 64'(fill[2:0]), 64'd3);
        #3;
        rst  = 1'b1;
        rptr = '0;
        #1;
        chk("mid_ready", 64'(ready), 64'(2'b11));
        chk("mid_fill",  64'(fill), 64'h0);
        chk("mid_af",    64'(af), 64'h0);
        chk("mid_wptr",  64'(wptr), 64'h0);
        chk("mid_data",  adata[63:0] | adata[127:64], 64'h0);
        cyc();
        rst = 1'b0;
        valid[0]   = 1'b1;
        data[15:0] = 16'hE0;
        cyc();
        valid[0] = 1'b0;
        chk("resume_wptr", 64'(wptr[2:0]), 64'(3'b001));
        chk("resume_fill", 64'(fill[2:0]), 64'd1);
        chk("resume_mem",  64'(slot(0, 0)), 64'hE0);
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
